// File: rtl/cache_pkg.sv
// Shared constants, FSM state encoding and helpers for the LRU refill controller.
// Line geometry is fixed here so the interface, top and assembler agree on widths.
package cache_pkg;
   localparam int TAGS_WIDTH = 48;
   localparam int DATA_WIDTH = 64;
   localparam int CACHE_SIZE = 512;
   localparam int CNT_WIDTH  = 32;
   localparam int BEATS      = CACHE_SIZE / DATA_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HIT_RSP,
      S_ADDR,
      S_DATA,
      S_FILL_RSP
   } state_t;

   // Ceiling log2, never below 1 so a single-beat line still gets a counter bit.
   function automatic int clogb2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction
endpackage

// File: rtl/lru_refill_ctrl_if.sv
// Lookup, backend, fill and response channels of the refill controller.
// slave is the controller side, master is the environment side.
interface lru_refill_ctrl_if;
   import cache_pkg::*;

   logic                  lk_tvalid;
   logic                  lk_tready;
   logic [TAGS_WIDTH-1:0] lk_tag;
   logic                  lk_hit;
   logic [CACHE_SIZE-1:0] lk_line;
   logic                  be_addr_tvalid;
   logic                  be_addr_tready;
   logic [TAGS_WIDTH-1:0] be_addr_tdata;
   logic                  be_data_tvalid;
   logic                  be_data_tready;
   logic [DATA_WIDTH-1:0] be_data_tdata;
   logic                  be_data_tlast;
   logic                  fill_valid;
   logic                  fill_ready;
   logic [TAGS_WIDTH-1:0] fill_tag;
   logic [CACHE_SIZE-1:0] fill_line;
   logic                  rsp_tvalid;
   logic                  rsp_tready;
   logic [CACHE_SIZE-1:0] rsp_tdata;
   logic                  rsp_hit;
   logic                  rsp_err;
   logic [CNT_WIDTH-1:0]  hit_cnt;
   logic [CNT_WIDTH-1:0]  miss_cnt;

   modport slave (
      input  lk_tvalid, lk_tag, lk_hit, lk_line, be_addr_tready,
             be_data_tvalid, be_data_tdata, be_data_tlast, fill_ready, rsp_tready,
      output lk_tready, be_addr_tvalid, be_addr_tdata, be_data_tready,
             fill_valid, fill_tag, fill_line, rsp_tvalid, rsp_tdata, rsp_hit,
             rsp_err, hit_cnt, miss_cnt
   );

   modport master (
      output lk_tvalid, lk_tag, lk_hit, lk_line, be_addr_tready,
             be_data_tvalid, be_data_tdata, be_data_tlast, fill_ready, rsp_tready,
      input  lk_tready, be_addr_tvalid, be_addr_tdata, be_data_tready,
             fill_valid, fill_tag, fill_line, rsp_tvalid, rsp_tdata, rsp_hit,
             rsp_err, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/refill_line_assembler.sv
// Packs backend beats into a cache line, beat 0 in the LSBs; flags completion and
// burst-length mismatch combinationally on the accepted beat that ends the line.
module refill_line_assembler
   import cache_pkg::*;
#(
   parameter int DW = DATA_WIDTH,
   parameter int CS = CACHE_SIZE
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          beat_vld_i,
   input  logic [DW-1:0] beat_dat_i,
   input  logic          beat_last_i,
   output logic [CS-1:0] line_o,
   output logic          done_o,
   output logic          err_o
);
   localparam int N_BEATS = CS / DW;
   localparam int CW      = clogb2(N_BEATS);

   logic [CW-1:0] cnt_q;
   logic [CS-1:0] line_q;
   logic          last_slot;

   assign last_slot = (cnt_q == CW'(N_BEATS - 1));
   assign done_o    = beat_vld_i & (beat_last_i | last_slot);
   // Short burst (early tlast) and long burst (no tlast in last slot) both mismatch.
   assign err_o     = beat_vld_i & (beat_last_i ^ last_slot);
   assign line_o    = line_q;

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         cnt_q  <= '0;
         line_q <= '0;
      end else if (beat_vld_i) begin
         line_q[int'(cnt_q)*DW +: DW] <= beat_dat_i;
         cnt_q                        <= cnt_q + CW'(1);
      end
   end
endmodule

// File: rtl/lru_refill_ctrl.sv
// Blocking miss handler: hits answer directly, misses fetch a burst, fill the way
// and answer the frontend; one transaction in flight, all outputs registered.
module lru_refill_ctrl
   import cache_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   lru_refill_ctrl_if.slave bus
);
   state_t                state_q;
   logic [TAGS_WIDTH-1:0] tag_q;
   logic [CACHE_SIZE-1:0] hit_line_q;
   logic                  lk_rdy_q, addr_vld_q, data_rdy_q, fill_vld_q, rsp_vld_q;
   logic                  rsp_hit_q, rsp_err_q;
   logic [CNT_WIDTH-1:0]  hit_cnt_q, miss_cnt_q;
   logic                  lk_acc, beat_acc, asm_clr, line_done, line_err;
   logic                  fill_vld_d, rsp_vld_d;
   logic [CACHE_SIZE-1:0] asm_line;

   assign lk_acc     = bus.lk_tvalid & lk_rdy_q;
   assign beat_acc   = bus.be_data_tvalid & data_rdy_q;
   assign asm_clr    = lk_acc & ~bus.lk_hit;
   assign fill_vld_d = fill_vld_q & ~bus.fill_ready;
   assign rsp_vld_d  = rsp_vld_q & ~bus.rsp_tready;

   refill_line_assembler u_asm (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (asm_clr),
      .beat_vld_i  (beat_acc),
      .beat_dat_i  (bus.be_data_tdata),
      .beat_last_i (bus.be_data_tlast),
      .line_o      (asm_line),
      .done_o      (line_done),
      .err_o       (line_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tag_q      <= '0;
         hit_line_q <= '0;
         lk_rdy_q   <= 1'b1;
         addr_vld_q <= 1'b0;
         data_rdy_q <= 1'b0;
         fill_vld_q <= 1'b0;
         rsp_vld_q  <= 1'b0;
         rsp_hit_q  <= 1'b0;
         rsp_err_q  <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (lk_acc) begin
               tag_q     <= bus.lk_tag;
               lk_rdy_q  <= 1'b0;
               rsp_hit_q <= bus.lk_hit;
               rsp_err_q <= 1'b0;
               if (bus.lk_hit) begin
                  hit_line_q <= bus.lk_line;
                  rsp_vld_q  <= 1'b1;
                  hit_cnt_q  <= sat_inc(hit_cnt_q);
                  state_q    <= S_HIT_RSP;
               end else begin
                  addr_vld_q <= 1'b1;
                  miss_cnt_q <= sat_inc(miss_cnt_q);
                  state_q    <= S_ADDR;
               end
            end
            S_HIT_RSP: if (bus.rsp_tready) begin
               rsp_vld_q <= 1'b0;
               lk_rdy_q  <= 1'b1;
               state_q   <= S_IDLE;
            end
            S_ADDR: if (bus.be_addr_tready) begin
               addr_vld_q <= 1'b0;
               data_rdy_q <= 1'b1;
               state_q    <= S_DATA;
            end
            S_DATA: if (line_done) begin
               data_rdy_q <= 1'b0;
               fill_vld_q <= 1'b1;
               rsp_vld_q  <= 1'b1;
               rsp_err_q  <= line_err;
               state_q    <= S_FILL_RSP;
            end
            S_FILL_RSP: begin
               // Each valid drops on its own handshake; leave once both have gone.
               fill_vld_q <= fill_vld_d;
               rsp_vld_q  <= rsp_vld_d;
               if (!fill_vld_d && !rsp_vld_d) begin
                  lk_rdy_q <= 1'b1;
                  state_q  <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.lk_tready      = lk_rdy_q;
   assign bus.be_addr_tvalid = addr_vld_q;
   assign bus.be_addr_tdata  = tag_q;
   assign bus.be_data_tready = data_rdy_q;
   assign bus.fill_valid     = fill_vld_q;
   assign bus.fill_tag       = tag_q;
   assign bus.fill_line      = asm_line;
   assign bus.rsp_tvalid     = rsp_vld_q;
   assign bus.rsp_tdata      = rsp_hit_q ? hit_line_q : asm_line;
   assign bus.rsp_hit        = rsp_hit_q;
   assign bus.rsp_err        = rsp_err_q;
   assign bus.hit_cnt        = hit_cnt_q;
   assign bus.miss_cnt       = miss_cnt_q;
endmodule

// File: tb/tb_lru_refill_ctrl.sv
// Directed scoreboard bench for lru_refill_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares on every handshake.
module tb_lru_refill_ctrl;
   import cache_pkg::*;

   typedef struct {
      logic [CACHE_SIZE-1:0] data;
      logic                  hit;
      logic                  err;
   } rsp_t;

   typedef struct {
      logic [TAGS_WIDTH-1:0] tag;
      logic [CACHE_SIZE-1:0] line;
   } fill_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lru_refill_ctrl_if bus();
   lru_refill_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   rsp_t                  exp_rsp[$];
   fill_t                 exp_fill[$];
   logic [TAGS_WIDTH-1:0] exp_addr[$];
   rsp_t                  er;
   fill_t                 ef;
   logic [TAGS_WIDTH-1:0] ea;
   logic [DATA_WIDTH-1:0] beat_buf[BEATS];
   logic [CACHE_SIZE-1:0] line;

   int checks = 0, errors = 0;
   int cyc = 0, acc_cyc = 0, rsp_cyc = 0, fill_cyc = 0, rsp_n = 0, fill_n = 0;

   logic [599:0] prev_rsp, prev_fill, prev_addr;
   logic         hold_rsp = 1'b0, hold_fill = 1'b0, hold_addr = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [599:0] act, input logic [599:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event not seen or not expected", name);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (hold_rsp)
            chk("rsp_stable", {bus.rsp_tvalid, bus.rsp_hit, bus.rsp_err, bus.rsp_tdata}, prev_rsp);
         if (hold_fill)
            chk("fill_stable", {bus.fill_valid, bus.fill_tag, bus.fill_line}, prev_fill);
         if (hold_addr)
            chk("addr_stable", {bus.be_addr_tvalid, bus.be_addr_tdata}, prev_addr);
         if (bus.rsp_tvalid && bus.rsp_tready) begin
            rsp_n++;
            rsp_cyc = cyc;
            if (exp_rsp.size() == 0) fail("rsp_unexpected");
            else begin
               er = exp_rsp.pop_front();
               chk("rsp_tdata", bus.rsp_tdata, er.data);
               chk("rsp_hit", bus.rsp_hit, er.hit);
               chk("rsp_err", bus.rsp_err, er.err);
            end
         end
         if (bus.fill_valid && bus.fill_ready) begin
            fill_n++;
            fill_cyc = cyc;
            if (exp_fill.size() == 0) fail("fill_unexpected");
            else begin
               ef = exp_fill.pop_front();
               chk("fill_tag", bus.fill_tag, ef.tag);
               chk("fill_line", bus.fill_line, ef.line);
            end
         end
         if (bus.be_addr_tvalid && bus.be_addr_tready) begin
            if (exp_addr.size() == 0) fail("addr_unexpected");
            else begin
               ea = exp_addr.pop_front();
               chk("be_addr_tdata", bus.be_addr_tdata, ea);
            end
         end
      end
      hold_rsp  = !rst && bus.rsp_tvalid && !bus.rsp_tready;
      hold_fill = !rst && bus.fill_valid && !bus.fill_ready;
      hold_addr = !rst && bus.be_addr_tvalid && !bus.be_addr_tready;
      prev_rsp  = {bus.rsp_tvalid, bus.rsp_hit, bus.rsp_err, bus.rsp_tdata};
      prev_fill = {bus.fill_valid, bus.fill_tag, bus.fill_line};
      prev_addr = {bus.be_addr_tvalid, bus.be_addr_tdata};
   end

   // Called #1 after a posedge; returns #1 after the accepting edge.
   task automatic lookup(input logic [TAGS_WIDTH-1:0] tag, input logic hit,
                         input logic [CACHE_SIZE-1:0] ln);
      int t;
      bus.lk_tvalid = 1'b1;
      bus.lk_tag    = tag;
      bus.lk_hit    = hit;
      bus.lk_line   = ln;
      t = 0;
      @(negedge clk);
      while (!bus.lk_tready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bus.lk_tready) fail("lookup_timeout");
      acc_cyc = cyc;
      @(posedge clk); #1;
      bus.lk_tvalid = 1'b0;
   endtask

   task automatic send_beats(input int n, input int last_idx, input bit gap);
      int t;
      for (int i = 0; i < n; i++) begin
         bus.be_data_tvalid = 1'b1;
         bus.be_data_tdata  = beat_buf[i];
         bus.be_data_tlast  = (i == last_idx);
         t = 0;
         @(negedge clk);
         while (!bus.be_data_tready && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (!bus.be_data_tready) fail("beat_timeout");
         @(posedge clk); #1;
         bus.be_data_tvalid = 1'b0;
         bus.be_data_tlast  = 1'b0;
         if (gap) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic wait_counts(input int rt, input int ft);
      int t;
      t = 0;
      while ((rsp_n < rt || fill_n < ft) && t < 200) begin
         @(negedge clk); #1;
         t++;
      end
      if (rsp_n < rt || fill_n < ft) fail("handshake_timeout");
      @(posedge clk); #1;
   endtask

   initial begin
      rst                = 1'b1;
      bus.lk_tvalid      = 1'b0;
      bus.lk_tag         = '0;
      bus.lk_hit         = 1'b0;
      bus.lk_line        = '0;
      bus.be_addr_tready = 1'b1;
      bus.be_data_tvalid = 1'b0;
      bus.be_data_tdata  = '0;
      bus.be_data_tlast  = 1'b0;
      bus.fill_ready     = 1'b1;
      bus.rsp_tready     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_lk_tready", bus.lk_tready, 1);
      chk("rst_valids", {bus.be_addr_tvalid, bus.fill_valid, bus.rsp_tvalid, bus.be_data_tready}, 0);
      chk("rst_data", {bus.rsp_tdata, bus.fill_tag, bus.be_addr_tdata, bus.rsp_hit, bus.rsp_err}, 0);
      chk("rst_cnts", {bus.hit_cnt, bus.miss_cnt}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Hit
      for (int i = 0; i < 16; i++) line[i*32 +: 32] = 32'hA5A5_0000 + i;
      exp_rsp.push_back('{data: line, hit: 1'b1, err: 1'b0});
      lookup(48'hDEAD_C0DE, 1'b1, line);
      @(negedge clk);
      chk("hit_rsp_latency", bus.rsp_tvalid, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("hit_lk_tready_back", bus.lk_tready, 1);
      chk("hit_cnts", {bus.hit_cnt, bus.miss_cnt}, {32'd1, 32'd0});
      @(posedge clk); #1;

      // Clean miss
      for (int k = 0; k < BEATS; k++) begin
         beat_buf[k] = DATA_WIDTH'(k);
         line[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(k);
      end
      exp_addr.push_back(48'h1234);
      exp_fill.push_back('{tag: 48'h1234, line: line});
      exp_rsp.push_back('{data: line, hit: 1'b0, err: 1'b0});
      lookup(48'h1234, 1'b0, '0);
      send_beats(BEATS, BEATS - 1, 1'b0);
      wait_counts(2, 1);
      chk("clean_same_cycle", rsp_cyc, fill_cyc);
      chk("clean_turnaround", rsp_cyc - acc_cyc + 1, BEATS + 3);
      chk("clean_miss_cnt", bus.miss_cnt, 1);

      // Short burst
      line = '0;
      beat_buf[0] = 64'hA; beat_buf[1] = 64'hB; beat_buf[2] = 64'hC;
      line[0 +: 64] = 64'hA; line[64 +: 64] = 64'hB; line[128 +: 64] = 64'hC;
      exp_addr.push_back(48'h55);
      exp_fill.push_back('{tag: 48'h55, line: line});
      exp_rsp.push_back('{data: line, hit: 1'b0, err: 1'b1});
      lookup(48'h55, 1'b0, '0);
      send_beats(3, 2, 1'b0);
      wait_counts(3, 2);
      chk("short_miss_cnt", bus.miss_cnt, 2);

      // Split handshakes: response first, fill held
      bus.fill_ready = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
         beat_buf[k] = 64'h100 + 64'(k);
         line[k*DATA_WIDTH +: DATA_WIDTH] = 64'h100 + 64'(k);
      end
      exp_addr.push_back(48'h77);
      exp_fill.push_back('{tag: 48'h77, line: line});
      exp_rsp.push_back('{data: line, hit: 1'b0, err: 1'b0});
      lookup(48'h77, 1'b0, '0);
      send_beats(BEATS, BEATS - 1, 1'b0);
      wait_counts(4, 2);
      repeat (4) begin
         @(negedge clk);
         chk("split_hold", {bus.fill_valid, bus.rsp_tvalid, bus.lk_tready}, 3'b100);
      end
      @(posedge clk); #1;
      bus.fill_ready = 1'b1;
      wait_counts(4, 3);
      @(negedge clk);
      chk("split_lk_tready", bus.lk_tready, 1);
      chk("split_order", fill_cyc > rsp_cyc, 1);
      @(posedge clk); #1;

      // Address backpressure and gapped beats
      bus.be_addr_tready = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
         beat_buf[k] = 64'hC0DE_0000_0000_0000 + 64'(k);
         line[k*DATA_WIDTH +: DATA_WIDTH] = 64'hC0DE_0000_0000_0000 + 64'(k);
      end
      exp_addr.push_back(48'hBEEF);
      exp_fill.push_back('{tag: 48'hBEEF, line: line});
      exp_rsp.push_back('{data: line, hit: 1'b0, err: 1'b0});
      lookup(48'hBEEF, 1'b0, '0);
      repeat (3) begin
         @(negedge clk);
         chk("bp_addr_held", {bus.be_addr_tvalid, bus.be_data_tready}, 2'b10);
      end
      @(posedge clk); #1;
      bus.be_addr_tready = 1'b1;
      send_beats(BEATS, BEATS - 1, 1'b1);
      wait_counts(5, 4);
      chk("bp_miss_cnt", bus.miss_cnt, 4);

      // Reset in the middle of DATA
      beat_buf[0] = 64'h1; beat_buf[1] = 64'h2; beat_buf[2] = 64'h3;
      exp_addr.push_back(48'h999);
      lookup(48'h999, 1'b0, '0);
      send_beats(3, -1, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", {bus.lk_tready, bus.be_data_tready}, 2'b10);
      chk("mid_rst_valids", {bus.be_addr_tvalid, bus.fill_valid, bus.rsp_tvalid}, 0);
      chk("mid_rst_data", {bus.fill_line, bus.rsp_tdata, bus.fill_tag}, 0);
      chk("mid_rst_cnts", {bus.hit_cnt, bus.miss_cnt}, 0);
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) line[i*64 +: 64] = 64'h5A5A_0000_0000_0000 + 64'(i);
      exp_rsp.push_back('{data: line, hit: 1'b1, err: 1'b0});
      lookup(48'h42, 1'b1, line);
      wait_counts(6, 4);
      chk("post_rst_cnts", {bus.hit_cnt, bus.miss_cnt}, {32'd1, 32'd0});

      chk("rsp_queue_drained", exp_rsp.size(), 0);
      chk("fill_queue_drained", exp_fill.size(), 0);
      chk("addr_queue_drained", exp_addr.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lru_refill_ctrl.md
# lru_refill_ctrl

Miss-handling stage directly downstream of the LRU tag/way lookup. Consumes one lookup result per transaction (tag plus hit/miss and the hit line). Hits are returned straight to the frontend. Misses are fetched from the backend as a burst of beats, assembled into a full cache line, and handed back to the way as a fill while the same line is returned to the frontend. One transaction is in flight at a time; the block is blocking, not hit-under-miss.

## Interface
- TAGS_WIDTH, 48, tag and backend address width
- DATA_WIDTH, 64, backend data beat width
- CACHE_SIZE, 512, cache line width in bits; must be a multiple of DATA_WIDTH
- CNT_WIDTH, 32, width of the hit and miss statistics counters
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- lk_tvalid / lk_tready  in / out  1  lookup result handshake
- lk_tag  in  TAGS_WIDTH  looked-up tag
- lk_hit  in  1  lookup hit
- lk_line  in  CACHE_SIZE  hit line; ignored on miss
- be_addr_tvalid / be_addr_tready  out / in  1  backend address request
- be_addr_tdata  out  TAGS_WIDTH  tag to fetch
- be_data_tvalid / be_data_tready  in / out  1  backend data beats
- be_data_tdata  in  DATA_WIDTH  beat payload
- be_data_tlast  in  1  last beat of the burst
- fill_valid / fill_ready  out / in  1  line fill back to the way
- fill_tag  out  TAGS_WIDTH  tag being filled
- fill_line  out  CACHE_SIZE  assembled line
- rsp_tvalid / rsp_tready  out / in  1  frontend response
- rsp_tdata  out  CACHE_SIZE  line returned
- rsp_hit  out  1  response came from a hit
- rsp_err  out  1  burst length mismatch on this miss
- hit_cnt, miss_cnt  out  CNT_WIDTH  saturating statistics counters

## Operation
- States:
  - IDLE → HIT_RSP on an accepted lookup with lk_hit=1.
  - IDLE → ADDR on an accepted lookup with lk_hit=0.
  - HIT_RSP → IDLE on rsp handshake.
  - ADDR → DATA on be_addr handshake.
  - DATA → FILL_RSP when the line is complete.
  - FILL_RSP → IDLE once both the fill and rsp handshakes have occurred.
- lk_tready = (state==IDLE). lk_tag, lk_hit and lk_line are registered on acceptance.
- BEATS = CACHE_SIZE/DATA_WIDTH. A beat counter of width clog2(BEATS) increments on each accepted data beat.
- Beat k lands in line bits [k*DATA_WIDTH +: DATA_WIDTH]; beat 0 occupies the LSBs.
- The line is cleared to zero when ADDR is entered.
- be_data_tready = (state==DATA).
- Line-complete conditions:
  - Accepted beat with count BEATS-1 and tlast=1: err=0.
  - Accepted beat with tlast=1 and count < BEATS-1 (short burst): remaining beats stay zero; err=1.
  - Accepted beat with count BEATS-1 and tlast=0 (long burst): err=1. The block leaves DATA; further beats are not accepted and remain the backend's responsibility.
- In FILL_RSP, fill_valid and rsp_tvalid assert together. A per-channel done flag drops each valid after its own handshake. The two handshakes may complete in the same cycle or in either order.
- rsp_tdata = fill_line; rsp_hit=0, rsp_err=err.
- On a hit: rsp_hit=1, rsp_err=0, no fill is issued.
- hit_cnt / miss_cnt increment on lookup acceptance and saturate at all-ones.
- All valid/data outputs hold stable while valid is high and ready is low.

## Timing
- Reset, in the cycle after rst is sampled high:
  - state=IDLE.
  - All tvalid/valid outputs 0, lk_tready=1, be_data_tready=0.
  - All data, tag, rsp_hit, rsp_err and counter outputs 0.
- Reset mid-transaction aborts it immediately. No further handshakes complete, and the backend must be reset alongside.
- Hit: lookup accepted in cycle N → rsp_tvalid=1 in N+1. lk_tready returns to 1 the cycle after the rsp handshake.
- Miss: lookup accepted in N → be_addr_tvalid=1 in N+1.
- be_data_tready rises in the cycle after the address handshake.
- Final beat accepted in M → fill_valid=rsp_tvalid=1 in M+1.
- Minimum miss turnaround with all readies high: BEATS+3 cycles from lookup acceptance to the final handshake.

## Structure
- Shared package cache_pkg holds:
  - the state enum;
  - a clogb2 function;
  - localparam BEATS derived from the parameters.
- One sub-module, refill_line_assembler, owns the beat counter, the shift-in of beats into the line, and tlast/err detection. It is cleared by the FSM on entry to ADDR.

## Test plan
- Hit, default parameters: lk_tag=0xDEADC0DE, lk_hit=1, lk_line=pattern P, rsp_tready=1 → rsp_tvalid in the next cycle with tdata=P, rsp_hit=1; no be_addr or fill activity; hit_cnt=1.
- Clean miss: tag 0x1234, 8 beats 0x0..0x7 with tlast on beat 7, all readies high → be_addr_tdata=0x1234; fill_line word k=k; fill and rsp in the same cycle; err=0; miss_cnt=1; BEATS+3 cycles total.
- Short burst: tlast on beat 2 (values 0xA, 0xB, 0xC) → line words 0..2 = 0xA, 0xB, 0xC, words 3..7 = 0; rsp_err=1.
- Split handshakes: fill_ready held low for 5 cycles, rsp_tready=1 → rsp completes first and fill_valid holds with a stable line until fill_ready; lk_tready stays 0 until the fill handshake.
- Backpressure: be_addr_tready low 3 cycles, be_data_tvalid gapped every other cycle → address stable, all 8 beats assembled correctly.
- rst asserted during DATA after 3 beats → next cycle idle outputs; a following hit completes normally with counters restarted from 0.
